// File: rtl/key_scan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : key_scan_pkg
//  Purpose  : Shared constants for the key scanner: key count, debounce
//             counter width, key-index width and event-type encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package key_scan_pkg;

   localparam int NUM_KEYS = 4;
   localparam int CNT_W    = 24;
   localparam int KEY_W    = $clog2(NUM_KEYS);

   // Event type carried on evt_press_o
   localparam logic EVT_PRESS   = 1'b1;
   localparam logic EVT_RELEASE = 1'b0;

endpackage : key_scan_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : One push-button channel: two-flop synchroniser, stability
//             counter, debounced state and one-cycle press/release strobes.
//  Ports    : clk, rst         - system clock, synchronous active-high reset
//             key_n            - raw button level, active-low, asynchronous
//             key_state        - debounced state, active-high, one cycle
//                                after the internal debounced bit flips
//             press_stb        - strobe on the cycle a press is accepted
//             release_stb      - strobe on the cycle a release is accepted
//  Revision : 1.0  initial release
// ============================================================================
module key_debounce
   import key_scan_pkg::*;
#(
   parameter logic [CNT_W-1:0] DEBOUNCE_CNT = 24'd1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic key_state,
   output logic press_stb,
   output logic release_stb
);

   localparam logic [CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT - CNT_W'(1);

   logic             sync_meta;
   logic             sync_lvl;
   logic             db;
   logic [CNT_W-1:0] cnt;
   logic             pressed;
   logic             done;

   assign pressed = ~sync_lvl;
   // The level has disagreed with the debounced state long enough: accept it.
   assign done    = (pressed != db) && (cnt == CNT_LAST);

   assign press_stb   = done & ~db;
   assign release_stb = done &  db;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta <= 1'b1;
         sync_lvl  <= 1'b1;
         db        <= 1'b0;
         cnt       <= '0;
         key_state <= 1'b0;
      end else begin
         sync_meta <= key_n;
         sync_lvl  <= sync_meta;
         key_state <= db;
         if (pressed == db) begin
            // Any return to the accepted level restarts the count, so short
            // glitches never get through.
            cnt <= '0;
         end else if (done) begin
            db  <= ~db;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule : key_debounce
`default_nettype wire

// File: rtl/key_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : key_scan
//  Purpose  : Debounces four active-low push buttons and reports press /
//             release events through a valid/ready output register.
//  Ports    : clk, rst         - system clock, synchronous active-high reset
//             key_i[3:0]       - raw buttons, active-low, asynchronous
//             key_o[3:0]       - debounced key state, active-high
//             evt_valid_o      - event available
//             evt_ready_i      - consumer accepts the event this cycle
//             evt_key_o[1:0]   - key index of the event
//             evt_press_o      - 1 = press, 0 = release
//             ovf_o            - sticky: an event was lost
//  Revision : 1.0  initial release
// ============================================================================
module key_scan
   import key_scan_pkg::*;
#(
   parameter logic [CNT_W-1:0] DEBOUNCE_CNT = 24'd1_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_i,
   output logic [NUM_KEYS-1:0] key_o,
   output logic                evt_valid_o,
   input  logic                evt_ready_i,
   output logic [KEY_W-1:0]    evt_key_o,
   output logic                evt_press_o,
   output logic                ovf_o
);

   logic [NUM_KEYS-1:0] press_stb;
   logic [NUM_KEYS-1:0] release_stb;
   logic [NUM_KEYS-1:0] pend_press;
   logic [NUM_KEYS-1:0] pend_rel;
   logic [NUM_KEYS-1:0] rel_first;   // 1: pending release is older than pending press
   logic [NUM_KEYS-1:0] set_press;
   logic [NUM_KEYS-1:0] set_rel;
   logic [NUM_KEYS-1:0] lost_press;
   logic [NUM_KEYS-1:0] lost_rel;
   logic [NUM_KEYS-1:0] clr_press;
   logic [NUM_KEYS-1:0] clr_rel;
   logic                load;
   logic                sel_found;
   logic [KEY_W-1:0]    sel_key;
   logic                sel_press;

   generate
      for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
         key_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
         ) u_debounce (
            .clk         (clk),
            .rst         (rst),
            .key_n       (key_i[k]),
            .key_state   (key_o[k]),
            .press_stb   (press_stb[k]),
            .release_stb (release_stb[k])
         );
      end
   endgenerate

   // A strobe is lost if the same event type for that key is already
   // pending or currently sitting in the output register.
   always_comb begin
      lost_press = '0;
      lost_rel   = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         lost_press[k] = press_stb[k] &
                         (pend_press[k] | (evt_valid_o && evt_key_o == KEY_W'(k) &&
                                           evt_press_o == EVT_PRESS));
         lost_rel[k]   = release_stb[k] &
                         (pend_rel[k]   | (evt_valid_o && evt_key_o == KEY_W'(k) &&
                                           evt_press_o == EVT_RELEASE));
      end
      set_press = press_stb   & ~lost_press;
      set_rel   = release_stb & ~lost_rel;
   end

   // Fixed priority: scan downward so the lowest pending key wins.
   always_comb begin
      load      = ~evt_valid_o | evt_ready_i;
      sel_found = 1'b0;
      sel_key   = '0;
      sel_press = EVT_PRESS;
      clr_press = '0;
      clr_rel   = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (pend_press[k] || pend_rel[k]) begin
            sel_found = 1'b1;
            sel_key   = KEY_W'(k);
            if (pend_press[k] && pend_rel[k]) begin
               sel_press = rel_first[k] ? EVT_RELEASE : EVT_PRESS;
            end else begin
               sel_press = pend_press[k] ? EVT_PRESS : EVT_RELEASE;
            end
         end
      end
      if (load && sel_found) begin
         if (sel_press == EVT_PRESS) begin
            clr_press[sel_key] = 1'b1;
         end else begin
            clr_rel[sel_key]   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_press  <= '0;
         pend_rel    <= '0;
         rel_first   <= '0;
         evt_valid_o <= 1'b0;
         evt_key_o   <= '0;
         evt_press_o <= EVT_RELEASE;
         ovf_o       <= 1'b0;
      end else begin
         pend_press <= (pend_press & ~clr_press) | set_press;
         pend_rel   <= (pend_rel   & ~clr_rel)   | set_rel;
         // The newest strobe marks the other type (if pending) as older.
         rel_first  <= (rel_first | press_stb) & ~release_stb;
         ovf_o      <= ovf_o | (|lost_press) | (|lost_rel);
         if (load) begin
            evt_valid_o <= sel_found;
            if (sel_found) begin
               evt_key_o   <= sel_key;
               evt_press_o <= sel_press;
            end
         end
      end
   end

endmodule : key_scan
`default_nettype wire

// File: tb/tb_key_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_key_scan
//  Purpose  : Directed self-checking bench for key_scan with DEBOUNCE_CNT=8.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_scan;

   logic       clk;
   logic       rst;
   logic [3:0] key_i;
   logic [3:0] key_o;
   logic       evt_valid_o;
   logic       evt_ready_i;
   logic [1:0] evt_key_o;
   logic       evt_press_o;
   logic       ovf_o;

   int checks   = 0;
   int failures = 0;

   logic [1:0] ev_key[$];
   logic       ev_press[$];

   key_scan #(
      .DEBOUNCE_CNT (24'd8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_i       (key_i),
      .key_o       (key_o),
      .evt_valid_o (evt_valid_o),
      .evt_ready_i (evt_ready_i),
      .evt_key_o   (evt_key_o),
      .evt_press_o (evt_press_o),
      .ovf_o       (ovf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every accepted event.
   always @(posedge clk) begin
      if (!rst && evt_valid_o && evt_ready_i) begin
         ev_key.push_back(evt_key_o);
         ev_press.push_back(evt_press_o);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      ev_key.delete();
      ev_press.delete();
   endtask

   initial begin
      rst         = 1'b1;
      key_i       = 4'hF;
      evt_ready_i = 1'b1;
      tick(3);
      check("rst_key_o", 32'(key_o), 32'h0);
      check("rst_valid", 32'(evt_valid_o), 32'h0);
      check("rst_evt_key", 32'(evt_key_o), 32'h0);
      check("rst_press", 32'(evt_press_o), 32'h0);
      check("rst_ovf", 32'(ovf_o), 32'h0);
      rst = 1'b0;
      tick(2);

      // Single clean press: key_o after 2 + 8 + 1 = 11 edges.
      key_i[0] = 1'b0;
      tick(10);
      check("t1_key_o_early", 32'(key_o), 32'h0);
      tick(1);
      check("t1_key_o", 32'(key_o), 32'h1);
      check("t1_valid", 32'(evt_valid_o), 32'h1);
      check("t1_key", 32'(evt_key_o), 32'h0);
      check("t1_press", 32'(evt_press_o), 32'h1);
      tick(1);
      check("t1_valid_drop", 32'(evt_valid_o), 32'h0);
      tick(8);
      key_i[0] = 1'b1;
      tick(11);
      check("t1_rel_key_o", 32'(key_o), 32'h0);
      check("t1_rel_valid", 32'(evt_valid_o), 32'h1);
      check("t1_rel_press", 32'(evt_press_o), 32'h0);
      tick(2);
      check("t1_nevents", 32'(ev_key.size()), 32'd2);
      clear_log();

      // Bouncing key 2: 3-cycle pulses never complete the count.
      for (int i = 0; i < 10; i++) begin
         key_i[2] = ~key_i[2];
         tick(3);
      end
      tick(20);
      check("t2_key_o", 32'(key_o), 32'h0);
      check("t2_nevents", 32'(ev_key.size()), 32'd0);
      check("t2_ovf", 32'(ovf_o), 32'h0);

      // Keys 1 and 3 pressed together: two back-to-back events.
      key_i[1] = 1'b0;
      key_i[3] = 1'b0;
      tick(11);
      check("t3_key_o", 32'(key_o), 32'hA);
      check("t3_valid_a", 32'(evt_valid_o), 32'h1);
      check("t3_key_a", 32'(evt_key_o), 32'h1);
      check("t3_press_a", 32'(evt_press_o), 32'h1);
      tick(1);
      check("t3_valid_b", 32'(evt_valid_o), 32'h1);
      check("t3_key_b", 32'(evt_key_o), 32'h3);
      check("t3_press_b", 32'(evt_press_o), 32'h1);
      tick(1);
      check("t3_valid_end", 32'(evt_valid_o), 32'h0);
      key_i = 4'hF;
      tick(16);
      check("t3_nevents", 32'(ev_key.size()), 32'd4);
      clear_log();

      // Stalled consumer: press held stable, release follows without bubble.
      evt_ready_i = 1'b0;
      key_i[0]    = 1'b0;
      tick(11);
      check("t4_valid", 32'(evt_valid_o), 32'h1);
      check("t4_key", 32'(evt_key_o), 32'h0);
      check("t4_press", 32'(evt_press_o), 32'h1);
      key_i[0] = 1'b1;
      tick(11);
      check("t4_key_o_rel", 32'(key_o), 32'h0);
      check("t4_hold_valid", 32'(evt_valid_o), 32'h1);
      check("t4_hold_key", 32'(evt_key_o), 32'h0);
      check("t4_hold_press", 32'(evt_press_o), 32'h1);
      tick(2);
      evt_ready_i = 1'b1;
      tick(1);
      check("t4_next_valid", 32'(evt_valid_o), 32'h1);
      check("t4_next_key", 32'(evt_key_o), 32'h0);
      check("t4_next_press", 32'(evt_press_o), 32'h0);
      tick(1);
      check("t4_valid_end", 32'(evt_valid_o), 32'h0);
      check("t4_ovf", 32'(ovf_o), 32'h0);
      check("t4_nevents", 32'(ev_key.size()), 32'd2);
      clear_log();

      // Overflow: press, release, press again while stalled.
      evt_ready_i = 1'b0;
      key_i[0]    = 1'b0;
      tick(12);
      key_i[0] = 1'b1;
      tick(12);
      key_i[0] = 1'b0;
      tick(9);
      check("t5_ovf_early", 32'(ovf_o), 32'h0);
      tick(1);
      check("t5_ovf", 32'(ovf_o), 32'h1);
      evt_ready_i = 1'b1;
      tick(5);
      check("t5_ovf_sticky", 32'(ovf_o), 32'h1);
      check("t5_nevents", 32'(ev_key.size()), 32'd2);
      clear_log();

      // Reset in the middle of a debounce with an event on the output.
      evt_ready_i = 1'b0;
      key_i[1]    = 1'b0;
      tick(11);
      check("t6_valid_pre", 32'(evt_valid_o), 32'h1);
      key_i[0] = 1'b1;
      tick(4);
      rst = 1'b1;
      tick(1);
      check("t6_key_o", 32'(key_o), 32'h0);
      check("t6_valid", 32'(evt_valid_o), 32'h0);
      check("t6_key", 32'(evt_key_o), 32'h0);
      check("t6_press", 32'(evt_press_o), 32'h0);
      check("t6_ovf", 32'(ovf_o), 32'h0);
      clear_log();
      rst         = 1'b0;
      evt_ready_i = 1'b1;
      tick(10);
      check("t6_held_early", 32'(key_o), 32'h0);
      check("t6_held_valid_early", 32'(evt_valid_o), 32'h0);
      tick(1);
      check("t6_held_key_o", 32'(key_o), 32'h2);
      check("t6_held_valid", 32'(evt_valid_o), 32'h1);
      check("t6_held_key", 32'(evt_key_o), 32'h1);
      check("t6_held_press", 32'(evt_press_o), 32'h1);
      tick(20);
      check("t6_nevents", 32'(ev_key.size()), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_key_scan
`default_nettype wire
